ula_commit_stage: RTL

//  Execute->writeback stage directly downstream of the ula. Captures ula result, rflags and destination

---
 rtl/ula_commit_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ula_commit_stage.sv
// ---------------------------------------------------------------------------
// ula_commit_stage
//   Execute -> writeback stage directly behind the ula. Each ula result
//   {opcode, rd, data, rflags} is captured into a 2-entry FIFO skid buffer.
//   The head entry drives the register-file write port, and the
//   architectural flags register is updated whenever an entry commits.
//   The stage decouples ula timing from register-file/branch-unit stalls
//   without dropping or reordering results.
//
//   Optional feature: define ULA_ERR_COUNT_EN to add the err_cnt port and a
//   saturating count of committed entries that carry rflags[0] (ERROR).
//
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   in_valid    upstream offers a ula result
//   in_ready    stage can accept a result (FIFO not full)
//   in_opcode   opcode that produced the result
//   in_rd       destination register
//   in_data     ula result
//   in_rflags   ula flags {OVERFLOW,ABOVE,EQUAL,BELOW,ERROR}
//   wb_valid    head entry presented for commit
//   wb_ready    writeback consumer accepts the head entry
//   wb_we       register-file write enable for the head entry
//   wb_rd       head destination register (0 when empty)
//   wb_data     head result (0 when empty)
//   flags_q     architectural flags register
//   err_cnt     committed-error count (ULA_ERR_COUNT_EN only)
// ---------------------------------------------------------------------------
module ula_commit_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int ERR_CNT_WIDTH  = 8,
    // Encoding of CMP in the processor opcode map
    parameter logic [OPCODE_WIDTH-1:0] OPC_CMP = 4'd7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [4:0]                in_rflags,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [4:0]                flags_q
`ifdef ULA_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
`endif
);

    // Entry storage: data is written only on push and never reset, the
    // count/pointers alone decide what is valid.
    logic [OPCODE_WIDTH-1:0]   opc_mem  [0:1];
    logic [REG_ADDR_WIDTH-1:0] rd_mem   [0:1];
    logic [DATA_WIDTH-1:0]     data_mem [0:1];
    logic [4:0]                flg_mem  [0:1];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic       push;
    logic       pop;
    logic [4:0] head_flags;
    logic       head_is_cmp;

    // in_ready depends on count only, so a pop in the same cycle does not
    // open a slot until the next cycle (no wb_ready -> in_ready path).
    assign in_ready    = (count != 2'd2);
    assign wb_valid    = (count != 2'd0);
    assign push        = in_valid & in_ready & ~rst;
    assign pop         = wb_valid & wb_ready & ~rst;

    assign head_flags  = flg_mem[rd_ptr];
    assign head_is_cmp = (opc_mem[rd_ptr] == OPC_CMP);

    // CMP and ERROR entries still commit (and update flags) but never write
    // the register file.
    assign wb_we   = wb_valid & ~head_is_cmp & ~head_flags[0];
    assign wb_rd   = wb_valid ? rd_mem[rd_ptr]   : '0;
    assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;

    // Control state: count, pointers and architectural flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= 5'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                flags_q <= head_flags;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry capture
    always_ff @(posedge clk) begin
        if (push) begin
            opc_mem[wr_ptr]  <= in_opcode;
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_data;
            flg_mem[wr_ptr]  <= in_rflags;
        end
    end

`ifdef ULA_ERR_COUNT_EN
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
        input logic [ERR_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pop && head_flags[0]) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`else
    logic [ERR_CNT_WIDTH-1:0] unused_err_w;
    assign unused_err_w = '0;
`endif

endmodule
